// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Multi-cycle multiply/divide unit holding the HI/LO register
//               pair. MULT/MULTU/MADD/MSUB occupy the unit for MUL_CYCLES
//               cycles and DIV/DIVU for DIV_CYCLES cycles. MTHI/MTLO write
//               the register pair directly without occupying the unit.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous reset, active low
//               start  - issue op this cycle (ignored while busy or flush)
//               op     - 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD 7 MSUB
//               A, B   - rs / rt operands
//               flush  - kill the in-flight operation, blocks a start
//               busy   - operation in progress
//               HI, LO - architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [2:0] c_OP_MADD  = 3'd6;
    localparam logic [2:0] c_OP_MSUB  = 3'd7;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // The counter is loaded with latency-1 so that the busy cycles holding
    // cnt = N-1 .. 0 number exactly N and the commit happens at cnt = 0.
    localparam logic [7:0] c_MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] c_DIV_LOAD = 8'(DIV_CYCLES - 1);

    logic [0:0]       r_state;
    logic [7:0]       r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;

    // ------------------------------------------------------------------
    // Datapath: evaluated from the captured operands, used at commit.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_acc;

    assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) *
                      $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_acc    = {r_hi, r_lo};

    // One unsigned divider serves both divides. For DIV the operands are
    // reduced to magnitudes and signs are restored afterwards; the most
    // negative value's magnitude is representable as unsigned, so
    // MIN / -1 naturally yields quotient MIN and remainder 0.
    logic             w_signed_div;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_num;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH-1:0] w_q_mag;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_signed_div = (r_op == c_OP_DIV);
    assign w_neg_a      = w_signed_div & r_a[WIDTH-1];
    assign w_neg_b      = w_signed_div & r_b[WIDTH-1];
    assign w_num        = w_neg_a ? (-r_a) : r_a;
    assign w_den        = w_neg_b ? (-r_b) : r_b;
    assign w_q_mag      = (w_den == '0) ? '0 : (w_num / w_den);
    assign w_r_mag      = (w_den == '0) ? '0 : (w_num % w_den);
    assign w_quot       = (w_neg_a ^ w_neg_b) ? (-w_q_mag) : w_q_mag;
    assign w_rem        = w_neg_a ? (-w_r_mag) : w_r_mag;

    logic [2*WIDTH-1:0] w_result;

    always_comb begin
        w_result = w_acc;
        case (r_op)
            c_OP_MULT:  w_result = w_prod_s;
            c_OP_MULTU: w_result = w_prod_u;
            c_OP_MADD:  w_result = w_acc + w_prod_s;
            c_OP_MSUB:  w_result = w_acc - w_prod_s;
            c_OP_DIV,
            c_OP_DIVU: begin
                if (r_b == '0) begin
                    // Divide by zero: all-ones quotient, dividend as remainder.
                    w_result = {r_a, {WIDTH{1'b1}}};
                end else begin
                    w_result = {w_rem, w_quot};
                end
            end
            default:    w_result = w_acc;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM with registered busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
            r_op    <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // A flush in the same cycle kills the issue, MTHI/MTLO included.
                    if (start && !flush) begin
                        case (op)
                            c_OP_MTHI: r_hi <= A;
                            c_OP_MTLO: r_lo <= A;
                            default: begin
                                r_op    <= op;
                                r_a     <= A;
                                r_b     <= B;
                                r_cnt   <= (op == c_OP_DIV || op == c_OP_DIVU) ?
                                           c_DIV_LOAD : c_MUL_LOAD;
                                r_state <= c_RUN;
                                r_busy  <= 1'b1;
                            end
                        endcase
                    end
                end
                c_RUN: begin
                    // start is ignored here; flush beats the commit.
                    if (flush) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == 8'd0) begin
                        r_hi    <= w_result[2*WIDTH-1:WIDTH];
                        r_lo    <= w_result[WIDTH-1:0];
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Self-checking bench for mdu_iter. A 32-bit instance is driven
//               with directed and random operations; expected HI/LO and busy
//               length are queued at issue and compared when busy falls. An
//               8-bit, single-cycle-multiply instance covers the narrow case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int c_MUL = 5;
    localparam int c_DIV = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = 8'd0;
    logic [7:0]  b8 = 8'd0;
    logic        flush8 = 1'b0;
    logic        busy8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .MUL_CYCLES(c_MUL), .DIV_CYCLES(c_DIV)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy), .HI(HI), .LO(LO)
    );

    mdu_iter #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(2)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
        .flush(flush8), .busy(busy8), .HI(hi8), .LO(lo8)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        bit          chk_len;
        string       name;
    } exp_t;

    exp_t q[$];

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint sa, sb, ma, mb, qq, rr;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = sa * sb;
        case (o)
            3'd0: return p;
            3'd1: return ua * ub;
            3'd6: return {hi, lo} + p;
            3'd7: return {hi, lo} - p;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                qq = ma / mb;
                rr = ma % mb;
                if ((sa < 0) != (sb < 0)) qq = -qq;
                if (sa < 0) rr = -rr;
                return {rr[31:0], qq[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    function automatic int lat(input logic [2:0] o);
        return (o == 3'd2 || o == 3'd3) ? c_DIV : c_MUL;
    endfunction

    // Monitor: compare against the scoreboard whenever busy falls.
    int  blen = 0;
    bit  prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            blen++;
        end else if (prev_busy) begin
            if (q.size() == 0) begin
                check("unexpected_completion", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check({e.name, "_hi"}, {32'd0, HI}, {32'd0, e.hi});
                check({e.name, "_lo"}, {32'd0, LO}, {32'd0, e.lo});
                if (e.chk_len) check({e.name, "_busy_len"}, 64'(blen), 64'(e.len));
            end
            blen = 0;
        end
        prev_busy = busy;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble operands while running; the captured copies must be used.
        A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        if (!done) check("wait_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo,
                        input int len, input bit chk_len);
        exp_t e;
        e.hi = hi; e.lo = lo; e.len = len; e.chk_len = chk_len; e.name = name;
        q.push_back(e);
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        logic [63:0] r;
        if (o == 3'd4 || o == 3'd5) begin
            if (o == 3'd4) m_hi = a; else m_lo = a;
            issue(o, a, b);
            @(negedge clk);
            check({name, "_hi"}, {32'd0, HI}, {32'd0, m_hi});
            check({name, "_lo"}, {32'd0, LO}, {32'd0, m_lo});
            check({name, "_nobusy"}, {63'd0, busy}, 64'd0);
        end else begin
            r = ref_op(o, a, b, m_hi, m_lo);
            m_hi = r[63:32];
            m_lo = r[31:0];
            push(name, m_hi, m_lo, lat(o), 1'b1);
            issue(o, a, b);
            wait_done();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_hilo8", {48'd0, hi8, lo8}, 64'd0);
        #3 reset = 1'b1;

        do_op("mult_m1x2", 3'd0, 32'hFFFF_FFFF, 32'd2);
        check("mult_m1x2_ref", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("div_m7by2", 3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_m7by2_ref", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_7by0", 3'd3, 32'd7, 32'd0);
        check("divu_7by0_ref", {m_hi, m_lo}, 64'h0000_0007_FFFF_FFFF);
        do_op("mthi_1", 3'd4, 32'h1234_5678, 32'd0);
        do_op("mthi_0", 3'd4, 32'd0, 32'd0);
        do_op("mtlo_f", 3'd5, 32'hFFFF_FFFF, 32'd0);
        do_op("madd_1x1", 3'd6, 32'd1, 32'd1);
        check("madd_1x1_ref", {m_hi, m_lo}, 64'h0000_0001_0000_0000);
        do_op("msub_3x5", 3'd7, 32'd3, 32'd5);
        do_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_m1_ref", {m_hi, m_lo}, 64'h0000_0000_8000_0000);
        do_op("div_by0", 3'd2, 32'hFFFF_FF00, 32'd0);

        // MULTU flushed in busy cycle 3: no commit, busy falls after 3 cycles.
        push("flush_c3", m_hi, m_lo, 3, 1'b1);
        issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done();

        // Flush in the commit cycle of a DIV suppresses the commit.
        push("flush_commit", m_hi, m_lo, c_DIV, 1'b1);
        issue(3'd3, 32'd100, 32'd7);
        repeat (c_DIV - 1) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done();

        // start together with flush in IDLE is ignored (MTHI and MULT).
        @(posedge clk); #1;
        start = 1'b1; op = 3'd4; A = 32'hCAFE_F00D; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_mthi", {HI, LO}, {m_hi, m_lo});
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; A = 32'd9; B = 32'd9; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_mult_busy", {63'd0, busy}, 64'd0);
        // flush alone in IDLE
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_idle", {HI, LO}, {m_hi, m_lo});

        // DIVU start while a MULT is busy is ignored.
        begin
            logic [63:0] r;
            r = ref_op(3'd0, 32'hFFFF_FFFD, 32'd7, m_hi, m_lo);
            m_hi = r[63:32]; m_lo = r[31:0];
            push("busy_start_ignored", m_hi, m_lo, c_MUL, 1'b1);
            issue(3'd0, 32'hFFFF_FFFD, 32'd7);
            start = 1'b1; op = 3'd3; A = 32'd7; B = 32'd0;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done();
        end

        // Narrow instance: MULT 0x80 * 0x80, one busy cycle.
        @(posedge clk); #1;
        start8 = 1'b1; op8 = 3'd0; a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy8) n++; else break;
        end
        check("w8_busy_len", 64'(n), 64'd1);
        check("w8_hilo", {48'd0, hi8, lo8}, 64'h4000);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) begin ra = ra >> 20; rb = rb >> 24; end
            do_op("rand", ro, ra, rb);
        end

        // Reset mid-RUN: immediate clear, no commit.
        push("reset_abort", 32'd0, 32'd0, 0, 1'b0);
        issue(3'd0, 32'd12345, 32'd678);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("reset_mid_busy", {63'd0, busy}, 64'd0);
        check("reset_mid_hilo", {HI, LO}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        #2 reset = 1'b1;

        // First start after reset release is accepted.
        do_op("post_reset_multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width in bits.
REQ-002 SHALL have parameter MUL_CYCLES, default 5: busy cycles for MULT/MULTU; legal range 1..255.
REQ-003 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: issue the operation on op this cycle.
REQ-007 SHALL have port op, input, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-008 SHALL have port A, input, WIDTH: rs operand.
REQ-009 SHALL have port B, input, WIDTH: rt operand.
REQ-010 SHALL have port flush, input, 1: exception or interrupt kill of the in-flight operation.
REQ-011 SHALL have port busy, output, 1: operation in progress.
REQ-012 SHALL have port HI, output, WIDTH: HI register.
REQ-013 SHALL have port LO, output, WIDTH: LO register.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and RUN, plus a down-counter cnt of 8 bits.
REQ-015 In IDLE, start with op 0-3 or 6-7 SHALL capture A and B and the op, load cnt with the latency, and enter RUN; busy SHALL go to 1 from the next cycle.
REQ-016 Latency SHALL be MUL_CYCLES for op 0, 1, 6 and 7, and DIV_CYCLES for op 2 and 3.
REQ-017 In RUN, cnt SHALL decrement each cycle; on the edge where cnt reaches 0, HI and LO SHALL be written, the FSM SHALL return to IDLE, and busy SHALL drop in the same cycle.
REQ-018 busy SHALL be 1 for exactly N consecutive cycles for latency N, and new HI/LO SHALL be visible in the first cycle busy is 0.
REQ-019 MTHI and MTLO SHALL write A to HI or LO on the next edge, SHALL NOT assert busy, and SHALL leave the other register unchanged.
REQ-020 MULT SHALL compute the signed product and MULTU the unsigned product, each 2*WIDTH bits, with {HI,LO} = product.
REQ-021 MADD SHALL compute {HI,LO} = {HI,LO} + signed(A*B) and MSUB {HI,LO} = {HI,LO} - signed(A*B), both modulo 2^(2*WIDTH), using the HI/LO values held at commit.
REQ-022 DIV SHALL produce LO = signed quotient truncated toward zero and HI = remainder carrying the sign of the dividend; DIVU SHALL produce the unsigned quotient and remainder.
REQ-023 On divide by zero, LO SHALL be all ones and HI SHALL equal A, for both DIV and DIVU.
REQ-024 DIV of the most negative value by -1 SHALL give LO = the most negative value and HI = 0, with no flag raised.
REQ-025 A start received while busy = 1 SHALL be ignored, with no effect on state, HI or LO.
REQ-026 flush in RUN SHALL return the FSM to IDLE on the next edge, leave HI and LO unchanged, and drop busy in the next cycle.
REQ-027 flush in the commit cycle (cnt = 0) SHALL suppress the commit.
REQ-028 flush and start in the same cycle SHALL cause start to be ignored, including for MTHI and MTLO.
REQ-029 flush in IDLE with no start SHALL have no effect.
REQ-030 Operands captured at start SHALL be used; changes on A and B during RUN SHALL NOT affect the result.

Reset
REQ-031 When reset = 0, the block SHALL immediately, independent of clk, set the FSM to IDLE, cnt = 0, busy = 0, HI = 0, LO = 0 and all captured operands to 0.
REQ-032 Reset asserted during RUN SHALL abort the operation with no commit.
REQ-033 After reset is released, the first start SHALL be accepted at the next rising edge.

Verification
REQ-034 Bench SHALL cover: MULT A=32'hFFFFFFFF (-1), B=2 -> busy high 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
REQ-035 Bench SHALL cover: DIV A=-7, B=2 -> after 10 busy cycles LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1); DIVU A=7, B=0 -> LO=32'hFFFFFFFF, HI=7.
REQ-036 Bench SHALL cover: MTHI A=32'h12345678, then MADD with HI=0, LO=32'hFFFFFFFF, A=1, B=1 -> HI=1, LO=0 after 5 cycles.
REQ-037 Bench SHALL cover: MULTU started, flush asserted in busy cycle 3 -> busy 0 next cycle, HI/LO keep prior values; start in a flush cycle is ignored.
REQ-038 Bench SHALL cover: start of DIVU while busy from a MULT -> ignored, MULT result committed normally; reset pulsed mid-RUN -> HI=LO=0 and busy=0 immediately.
REQ-039 Bench SHALL cover: WIDTH=8, MUL_CYCLES=1 with MULT A=8'h80, B=8'h80 -> busy exactly 1 cycle, HI=8'h40, LO=8'h00.
